axis_packet_arbiter: RTL and testbench

//  Single-clock, packet-atomic N:1 AXI-Stream arbiter. Successor to the async axisMux.

---
 rtl/axis_packet_arbiter.sv | 155 +++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic N:1 AXI-Stream arbiter with round-robin or fixed priority,
// per-source enable mask, source tagging and runaway-packet truncation.
module axis_packet_arbiter #(
    parameter int NUM_SOURCES   = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int USER_WIDTH    = 1,
    parameter int ARB_MODE      = 0,
    parameter int MAX_PKT_WORDS = 16,
    localparam int SRC_W        = $clog2(NUM_SOURCES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES-1:0]            srcEnable,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    output logic [NUM_SOURCES-1:0]            s_tready,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    input  logic [DATA_WIDTH*NUM_SOURCES-1:0] s_tdata,
    input  logic [USER_WIDTH*NUM_SOURCES-1:0] s_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [USER_WIDTH-1:0]             m_tuser,
    output logic [SRC_W-1:0]                  m_tsrc,
    output logic                              truncStrobe
);

    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] grant, grant_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [SRC_W-1:0] ptr_after;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [NUM_SOURCES-1:0] req;
    logic [SRC_W-1:0] pick;
    logic             pick_ok;
    int               idx;
    logic             ready_g;
    logic             acc;
    logic             cur_last;
    logic             trunc;
    logic             load;

    // Arbitration: scan requests from rr_ptr (round-robin) or from 0 (fixed)
    always_comb begin
        req     = s_tvalid & srcEnable;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (ARB_MODE == 1) idx = i;
            else idx = (int'(rr_ptr) + i) % NUM_SOURCES;
            if (!pick_ok && req[idx]) begin
                pick    = SRC_W'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    // Handshake with the granted source; truncation on the last allowed beat
    always_comb begin
        ready_g   = 1'b0;
        if (state == PASS) ready_g = !m_tvalid || m_tready;
        if (state == DROP) ready_g = 1'b1;
        acc       = s_tvalid[grant] && ready_g;
        cur_last  = s_tlast[grant];
        trunc     = (state == PASS) && acc && !cur_last &&
                    (beat_cnt == CNT_W'(MAX_PKT_WORDS - 1));
        ptr_after = (grant == SRC_W'(NUM_SOURCES - 1)) ? '0 : grant + SRC_W'(1);
    end

    // Next-state logic and per-source ready decode
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        s_tready     = '0;
        load         = 1'b0;
        unique case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (pick_ok) begin
                    grant_nxt = pick;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                s_tready[grant] = ready_g;
                if (acc) begin
                    load         = 1'b1;
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (cur_last) begin
                        rr_ptr_nxt   = ptr_after;
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else if (trunc) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = DROP;
                    end
                end
            end
            DROP: begin
                s_tready[grant] = ready_g;
                if (acc && cur_last) begin
                    rr_ptr_nxt = ptr_after;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Output register: loads on accepted beat, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= '0;
            m_tuser     <= '0;
            m_tsrc      <= '0;
            truncStrobe <= 1'b0;
        end else begin
            truncStrobe <= trunc;
            if (load) begin
                m_tvalid <= 1'b1;
                m_tlast  <= cur_last || trunc;
                m_tdata  <= s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                m_tuser  <= s_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
                m_tsrc   <= grant;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed scoreboard bench for axis_packet_arbiter.
// Second instance in fixed-priority mode covers priority behaviour.
module tb_axis_packet_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int UW   = 1;
    localparam int MAXW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    srcEnable, s_tvalid, s_tready, s_tlast;
    logic [DW*N-1:0] s_tdata;
    logic [UW*N-1:0] s_tuser;
    logic            m_tvalid, m_tready, m_tlast, truncStrobe;
    logic [DW-1:0]   m_tdata;
    logic [UW-1:0]   m_tuser;
    logic [1:0]      m_tsrc;

    logic [N-1:0]    fp_valid, fp_ready, fp_last;
    logic [DW*N-1:0] fp_data;
    logic [UW*N-1:0] fp_user;
    logic            fp_m_tvalid, fp_m_tlast, fp_trunc;
    logic [DW-1:0]   fp_m_tdata;
    logic [UW-1:0]   fp_m_tuser;
    logic [1:0]      fp_m_tsrc;

    axis_packet_arbiter #(
        .NUM_SOURCES(N), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .ARB_MODE(0), .MAX_PKT_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .srcEnable(srcEnable),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tsrc(m_tsrc),
        .truncStrobe(truncStrobe)
    );

    axis_packet_arbiter #(
        .NUM_SOURCES(N), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .ARB_MODE(1), .MAX_PKT_WORDS(MAXW)
    ) dut_fp (
        .clk(clk), .rst(rst), .srcEnable(4'hF),
        .s_tvalid(fp_valid), .s_tready(fp_ready), .s_tlast(fp_last),
        .s_tdata(fp_data), .s_tuser(fp_user),
        .m_tvalid(fp_m_tvalid), .m_tready(1'b1), .m_tlast(fp_m_tlast),
        .m_tdata(fp_m_tdata), .m_tuser(fp_m_tuser), .m_tsrc(fp_m_tsrc),
        .truncStrobe(fp_trunc)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] d;
    } beat_t;

    beat_t       sq [N][$];
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          trunc_cnt = 0;
    int          fp_beats = 0;
    bit          rdy_rand = 0;
    bit          fp_on = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_word;

    function automatic logic [31:0] mkd(int src, int pkt, int b);
        return {8'(src), 8'(pkt), 16'(b)};
    endfunction

    function automatic logic [63:0] mkw(int src, logic last, logic [31:0] d);
        return {28'd0, 2'(src), last, d[0], d};
    endfunction

    task automatic chk(string tag, logic [71:0] got, logic [71:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic load_pkt(int src, int pkt, int len);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.d    = mkd(src, pkt, b);
            x.last = (b == len - 1);
            sq[src].push_back(x);
        end
    endtask

    task automatic expect_pkt(int src, int pkt, int len);
        int n;
        n = (len > MAXW) ? MAXW : len;
        for (int b = 0; b < n; b++)
            exp_q.push_back(mkw(src, b == n - 1, mkd(src, pkt, b)));
    endtask

    task automatic cyc();
        logic [N-1:0] fire;
        logic [63:0]  word;
        logic [63:0]  e;
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
                s_tvalid[i]         = 1'b1;
                s_tlast[i]          = sq[i][0].last;
                s_tdata[i*DW +: DW] = sq[i][0].d;
                s_tuser[i]          = sq[i][0].d[0];
            end else begin
                s_tvalid[i]         = 1'b0;
                s_tlast[i]          = 1'b0;
                s_tdata[i*DW +: DW] = '0;
                s_tuser[i]          = 1'b0;
            end
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        word = {28'd0, m_tsrc, m_tlast, m_tuser, m_tdata};
        if (prev_stall) chk("stable", {m_tvalid, word}, {1'b1, prev_word});
        if (exp_q.size() == 0) begin
            chk("extra_out", m_tvalid && m_tready, 0);
        end else if (m_tvalid && m_tready) begin
            e = exp_q.pop_front();
            chk("out_beat", word, e);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_word  = word;
        if (truncStrobe) trunc_cnt++;
        if (fp_on) begin
            chk("fp_rdy3", fp_ready[3], 0);
            if (fp_m_tvalid) begin
                chk("fp_src", fp_m_tsrc, 1);
                fp_beats++;
            end
        end
        fire = s_tvalid & s_tready;
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (fire[i]) void'(sq[i].pop_front());
        @(negedge clk);
    endtask

    task automatic run_until(int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (4) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        cyc();
        cyc();
        rst = 1'b0;
        prev_stall = 1'b0;
        #1;
        chk("rst_state",
            {m_tvalid, m_tlast, m_tdata, m_tuser, m_tsrc, s_tready, truncStrobe},
            0);
        @(negedge clk);
    endtask

    initial begin
        srcEnable = 4'hF;
        m_tready  = 1'b1;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        s_tuser   = '0;
        fp_valid  = '0;
        fp_last   = '0;
        fp_data   = '0;
        fp_user   = '0;
        @(negedge clk);
        do_reset();

        // round-robin fairness
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) begin
                load_pkt(s, p, 3);
                expect_pkt(s, p, 3);
            end
        run_until(200);

        // fixed priority on the second instance
        fp_valid = 4'b1010;
        fp_last  = 4'hF;
        fp_data  = {32'h33, 32'h22, 32'h11, 32'h00};
        fp_on    = 1'b1;
        repeat (20) cyc();
        fp_on    = 1'b0;
        fp_valid = '0;
        chk("fp_beats", fp_beats > 5, 1);

        // truncation and rotation after drop
        do_reset();
        trunc_cnt = 0;
        load_pkt(0, 0, 20);
        load_pkt(0, 1, 2);
        load_pkt(1, 0, 3);
        expect_pkt(0, 0, 20);
        expect_pkt(1, 0, 3);
        expect_pkt(0, 1, 2);
        run_until(300);
        chk("trunc_cnt", trunc_cnt, 1);
        chk("drop_q0", sq[0].size(), 0);

        // random backpressure, exact-max packets not truncated
        do_reset();
        trunc_cnt = 0;
        rdy_rand  = 1'b1;
        load_pkt(0, 0, 3);  load_pkt(2, 0, 2);
        load_pkt(0, 1, 16); load_pkt(2, 1, 7);
        load_pkt(0, 2, 1);  load_pkt(2, 2, 16);
        load_pkt(0, 3, 5);  load_pkt(2, 3, 4);
        for (int p = 0; p < 4; p++) begin
            expect_pkt(0, p, (p == 0) ? 3 : (p == 1) ? 16 : (p == 2) ? 1 : 5);
            expect_pkt(2, p, (p == 0) ? 2 : (p == 1) ? 7 : (p == 2) ? 16 : 4);
        end
        run_until(2000);
        rdy_rand = 1'b0;
        chk("no_trunc", trunc_cnt, 0);

        // enable mask
        do_reset();
        srcEnable = 4'b0101;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) load_pkt(s, p, 2);
        expect_pkt(0, 0, 2);
        expect_pkt(2, 0, 2);
        expect_pkt(0, 1, 2);
        expect_pkt(2, 1, 2);
        run_until(200);
        chk("mask_q1", sq[1].size(), 4);
        srcEnable = 4'hF;

        // reset mid-packet
        do_reset();
        load_pkt(0, 0, 1);
        expect_pkt(0, 0, 1);
        run_until(50);
        load_pkt(1, 0, 4);
        expect_pkt(1, 0, 4);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 2 && n < 50) begin
                cyc();
                n++;
            end
            chk("mid_beats", exp_q.size(), 2);
        end
        rst = 1'b1;
        cyc();
        #1;
        chk("mid_rst", {m_tvalid, s_tready}, 0);
        @(negedge clk);
        prev_stall = 1'b0;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        rst = 1'b0;
        load_pkt(0, 5, 2);
        load_pkt(1, 5, 2);
        expect_pkt(0, 5, 2);
        expect_pkt(1, 5, 2);
        run_until(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
